// File: rtl/eth_pkt_fifo.sv
// eth_pkt_fifo: single-clock store-and-forward packet FIFO for the MAC
// FIFO-side streaming interface. Whole frames are committed on a good eop;
// errored, truncated (sop before eop) or overflowing frames are rolled back
// and never reach the read side.
//
// Ports:
//   clk, reset             single clock, synchronous active-high reset
//   in_data/sop/eop/mod    write beat (byte 0 in MSBs, mod = invalid bytes on eop)
//   in_err                 on eop: discard frame
//   in_wren / in_rdy       write strobe / space available
//   out_data/sop/eop/mod   read beat from the output register
//   out_dval / out_rdy     read beat valid / sink accepts
//   a_full, a_empty        free <= A_FULL, committed unread <= A_EMPTY
//   septy                  no complete frame stored
//   pkt_cnt                complete frames stored and not fully read
//   drop_cnt               discarded frames, saturating
module eth_pkt_fifo #(
  parameter  int DATA_W  = 32,
  parameter  int DEPTH   = 512,
  parameter  int A_FULL  = 8,
  parameter  int A_EMPTY = 8,
  localparam int MOD_W   = $clog2(DATA_W / 8),
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sop,
  input  logic              in_eop,
  input  logic [MOD_W-1:0]  in_mod,
  input  logic              in_err,
  input  logic              in_wren,
  output logic              in_rdy,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sop,
  output logic              out_eop,
  output logic [MOD_W-1:0]  out_mod,
  output logic              out_dval,
  input  logic              out_rdy,
  output logic              a_full,
  output logic              a_empty,
  output logic              septy,
  output logic [AW:0]       pkt_cnt,
  output logic [15:0]       drop_cnt
);

  localparam int          MEM_W     = DATA_W + 2 + MOD_W;
  localparam logic [AW:0] PTR_ONE   = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] DEPTH_V   = (AW+1)'(DEPTH);
  localparam logic [AW:0] A_FULL_V  = (AW+1)'(A_FULL);
  localparam logic [AW:0] A_EMPTY_V = (AW+1)'(A_EMPTY);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DISCARD} state_t;

  logic [MEM_W-1:0] mem [DEPTH];

  state_t      state, state_n;
  logic [AW:0] wptr, wptr_c, rptr;
  logic [AW:0] wptr_n, wptr_c_n;
  logic [AW:0] used, committed, free_w;
  logic        accept, overflow, commit, wr_en;
  logic [AW-1:0] wr_addr;
  logic [1:0]  drop_inc;
  logic [16:0] drop_sum;
  logic        rd_issue, rd_eop_xfer;

  assign used      = wptr - rptr;
  assign committed = wptr_c - rptr;
  assign free_w    = DEPTH_V - used;
  assign in_rdy    = (used < DEPTH_V);
  assign a_full    = (free_w <= A_FULL_V);
  assign a_empty   = (committed <= A_EMPTY_V);
  assign septy     = (pkt_cnt == '0);

  assign accept   = in_wren && in_rdy;
  assign overflow = in_wren && !in_rdy;

  // Write-side next state. In IDLE wptr always equals wptr_c, so a new
  // frame starts at the committed pointer in every path.
  always_comb begin
    state_n  = state;
    wptr_n   = wptr;
    wptr_c_n = wptr_c;
    wr_en    = 1'b0;
    wr_addr  = wptr[AW-1:0];
    commit   = 1'b0;
    drop_inc = 2'd0;
    case (state)
      S_IDLE: begin
        if (accept && in_sop) begin
          wr_en = 1'b1;
          if (!in_eop) begin
            wptr_n  = wptr + PTR_ONE;
            state_n = S_WRITE;
          end else if (in_err) begin
            drop_inc = 2'd1;
          end else begin
            wptr_n   = wptr + PTR_ONE;
            wptr_c_n = wptr + PTR_ONE;
            commit   = 1'b1;
          end
        end
      end
      S_WRITE: begin
        if (overflow) begin
          wptr_n   = wptr_c;
          drop_inc = 2'd1;
          state_n  = in_eop ? S_IDLE : S_DISCARD;
        end else if (accept) begin
          if (in_sop) begin
            // Truncated frame: roll back and restart at the committed pointer.
            wr_en    = 1'b1;
            wr_addr  = wptr_c[AW-1:0];
            drop_inc = 2'd1;
            if (!in_eop) begin
              wptr_n = wptr_c + PTR_ONE;
            end else if (in_err) begin
              wptr_n   = wptr_c;
              drop_inc = 2'd2;
              state_n  = S_IDLE;
            end else begin
              wptr_n   = wptr_c + PTR_ONE;
              wptr_c_n = wptr_c + PTR_ONE;
              commit   = 1'b1;
              state_n  = S_IDLE;
            end
          end else if (in_eop) begin
            if (in_err) begin
              wptr_n   = wptr_c;
              drop_inc = 2'd1;
            end else begin
              wr_en    = 1'b1;
              wptr_n   = wptr + PTR_ONE;
              wptr_c_n = wptr + PTR_ONE;
              commit   = 1'b1;
            end
            state_n = S_IDLE;
          end else begin
            wr_en  = 1'b1;
            wptr_n = wptr + PTR_ONE;
          end
        end
      end
      S_DISCARD: begin
        if (in_wren && in_eop) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign drop_sum = {1'b0, drop_cnt} + {15'd0, drop_inc};

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= {in_data, in_sop, in_eop, in_mod};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      wptr     <= '0;
      wptr_c   <= '0;
      drop_cnt <= '0;
    end else begin
      state    <= state_n;
      wptr     <= wptr_n;
      wptr_c   <= wptr_c_n;
      drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

  // The RAM read register doubles as the output register, so a committed
  // word reaches out_dval one cycle after wptr_c moves past it.
  assign rd_issue    = (rptr != wptr_c) && (!out_dval || out_rdy);
  assign rd_eop_xfer = out_dval && out_rdy && out_eop;

  always_ff @(posedge clk) begin
    if (reset) begin
      rptr     <= '0;
      out_dval <= 1'b0;
      out_data <= '0;
      out_sop  <= 1'b0;
      out_eop  <= 1'b0;
      out_mod  <= '0;
    end else if (rd_issue) begin
      {out_data, out_sop, out_eop, out_mod} <= mem[rptr[AW-1:0]];
      out_dval <= 1'b1;
      rptr     <= rptr + PTR_ONE;
    end else if (out_rdy) begin
      out_dval <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_cnt <= '0;
    end else if (commit && !rd_eop_xfer) begin
      pkt_cnt <= pkt_cnt + PTR_ONE;
    end else if (!commit && rd_eop_xfer) begin
      pkt_cnt <= pkt_cnt - PTR_ONE;
    end
  end

endmodule

// File: tb/tb_eth_pkt_fifo.sv
module tb_eth_pkt_fifo;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int MOD_W  = 2;
  localparam int AW     = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_sop = 1'b0, in_eop = 1'b0, in_err = 1'b0, in_wren = 1'b0;
  logic [MOD_W-1:0]  in_mod = '0;
  logic              in_rdy;
  logic [DATA_W-1:0] out_data;
  logic              out_sop, out_eop, out_dval;
  logic [MOD_W-1:0]  out_mod;
  logic              out_rdy = 1'b0;
  logic              a_full, a_empty, septy;
  logic [AW:0]       pkt_cnt;
  logic [15:0]       drop_cnt;

  int checks = 0;
  int errors = 0;
  logic [35:0] q[$];

  always #5 clk = ~clk;

  eth_pkt_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .A_FULL(4), .A_EMPTY(2)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_sop(in_sop), .in_eop(in_eop), .in_mod(in_mod),
    .in_err(in_err), .in_wren(in_wren), .in_rdy(in_rdy),
    .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop), .out_mod(out_mod),
    .out_dval(out_dval), .out_rdy(out_rdy),
    .a_full(a_full), .a_empty(a_empty), .septy(septy),
    .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
  );

  // Record every transferred output beat.
  always @(negedge clk) begin
    if (!reset && out_dval && out_rdy) q.push_back({out_data, out_sop, out_eop, out_mod});
  end

  function automatic logic [35:0] pk(input logic [31:0] d, input logic s, input logic e,
                                     input logic [1:0] m);
    return {d, s, e, m};
  endfunction

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic idle_in();
    in_wren = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_err = 1'b0; in_mod = '0; in_data = '0;
  endtask

  task automatic beat(input logic [31:0] d, input logic s, input logic e,
                      input logic [1:0] m, input logic er);
    in_data = d; in_sop = s; in_eop = e; in_mod = m; in_err = er; in_wren = 1'b1;
    cyc();
    idle_in();
  endtask

  task automatic test_reset();
    reset = 1'b1; idle_in(); out_rdy = 1'b0;
    cyc(); cyc();
    reset = 1'b0;
    checks++; if (out_dval !== 1'b0) begin errors++; $display("FAIL rst_dval: got %b exp 0", out_dval); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL rst_data: got %h exp 0", out_data); end
    checks++; if (pkt_cnt !== 5'd0) begin errors++; $display("FAIL rst_pkt_cnt: got %0d exp 0", pkt_cnt); end
    checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL rst_drop_cnt: got %0d exp 0", drop_cnt); end
    checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL rst_in_rdy: got %b exp 1", in_rdy); end
    checks++; if (a_full !== 1'b0) begin errors++; $display("FAIL rst_a_full: got %b exp 0", a_full); end
    checks++; if (a_empty !== 1'b1) begin errors++; $display("FAIL rst_a_empty: got %b exp 1", a_empty); end
    checks++; if (septy !== 1'b1) begin errors++; $display("FAIL rst_septy: got %b exp 1", septy); end
  endtask

  task automatic test_basic();
    logic [31:0] ed;
    logic        es, ee;
    logic [1:0]  em;
    out_rdy = 1'b1; q.delete();
    for (int i = 0; i < 4; i++) beat(32'hA000_0000 + i, i == 0, i == 3, (i == 3) ? 2'd2 : 2'd0, 1'b0);
    // cycle N+1
    checks++; if (out_dval !== 1'b0) begin errors++; $display("FAIL basic_dval_n1: got %b exp 0", out_dval); end
    checks++; if (pkt_cnt !== 5'd1) begin errors++; $display("FAIL basic_pkt_n1: got %0d exp 1", pkt_cnt); end
    checks++; if (septy !== 1'b0) begin errors++; $display("FAIL basic_septy_n1: got %b exp 0", septy); end
    cyc();
    for (int i = 0; i < 4; i++) begin
      ed = 32'hA000_0000 + i; es = (i == 0); ee = (i == 3); em = (i == 3) ? 2'd2 : 2'd0;
      checks++; if (out_dval !== 1'b1) begin errors++; $display("FAIL basic_dval[%0d]: got %b exp 1", i, out_dval); end
      checks++; if (out_data !== ed) begin errors++; $display("FAIL basic_data[%0d]: got %h exp %h", i, out_data, ed); end
      checks++; if (out_sop !== es) begin errors++; $display("FAIL basic_sop[%0d]: got %b exp %b", i, out_sop, es); end
      checks++; if (out_eop !== ee) begin errors++; $display("FAIL basic_eop[%0d]: got %b exp %b", i, out_eop, ee); end
      checks++; if (out_mod !== em) begin errors++; $display("FAIL basic_mod[%0d]: got %0d exp %0d", i, out_mod, em); end
      cyc();
    end
    checks++; if (out_dval !== 1'b0) begin errors++; $display("FAIL basic_dval_end: got %b exp 0", out_dval); end
    checks++; if (pkt_cnt !== 5'd0) begin errors++; $display("FAIL basic_pkt_end: got %0d exp 0", pkt_cnt); end
    checks++; if (septy !== 1'b1) begin errors++; $display("FAIL basic_septy_end: got %b exp 1", septy); end
  endtask

  task automatic test_err_frame();
    logic [35:0] exp_q [3];
    out_rdy = 1'b0; q.delete();
    for (int i = 0; i < 12; i++) beat(32'hE000_0000 + i, i == 0, 1'b0, 2'd0, 1'b0);
    checks++; if (a_full !== 1'b1) begin errors++; $display("FAIL err_a_full_12: got %b exp 1", a_full); end
    checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL err_in_rdy_12: got %b exp 1", in_rdy); end
    beat(32'hE000_000C, 1'b0, 1'b1, 2'd1, 1'b1);
    checks++; if (a_full !== 1'b0) begin errors++; $display("FAIL err_a_full_rb: got %b exp 0", a_full); end
    checks++; if (drop_cnt !== 16'd1) begin errors++; $display("FAIL err_drop: got %0d exp 1", drop_cnt); end
    checks++; if (pkt_cnt !== 5'd0) begin errors++; $display("FAIL err_pkt: got %0d exp 0", pkt_cnt); end
    checks++; if (a_empty !== 1'b1) begin errors++; $display("FAIL err_a_empty: got %b exp 1", a_empty); end
    checks++; if (out_dval !== 1'b0) begin errors++; $display("FAIL err_dval: got %b exp 0", out_dval); end
    beat(32'h6000_0000, 1'b1, 1'b0, 2'd0, 1'b0);
    beat(32'h6000_0001, 1'b0, 1'b0, 2'd0, 1'b0);
    beat(32'h6000_0002, 1'b0, 1'b1, 2'd3, 1'b0);
    checks++; if (pkt_cnt !== 5'd1) begin errors++; $display("FAIL good_pkt: got %0d exp 1", pkt_cnt); end
    checks++; if (a_empty !== 1'b0) begin errors++; $display("FAIL good_a_empty_3: got %b exp 0", a_empty); end
    checks++; if (a_full !== 1'b0) begin errors++; $display("FAIL good_a_full: got %b exp 0", a_full); end
    checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL good_in_rdy: got %b exp 1", in_rdy); end
    cyc();
    checks++; if (out_dval !== 1'b1) begin errors++; $display("FAIL good_dval: got %b exp 1", out_dval); end
    checks++; if (out_data !== 32'h6000_0000) begin errors++; $display("FAIL good_first: got %h exp 60000000", out_data); end
    checks++; if (a_empty !== 1'b1) begin errors++; $display("FAIL good_a_empty_2: got %b exp 1", a_empty); end
    out_rdy = 1'b1;
    repeat (6) cyc();
    exp_q[0] = pk(32'h6000_0000, 1'b1, 1'b0, 2'd0);
    exp_q[1] = pk(32'h6000_0001, 1'b0, 1'b0, 2'd0);
    exp_q[2] = pk(32'h6000_0002, 1'b0, 1'b1, 2'd3);
    checks++; if (q.size() != 3) begin errors++; $display("FAIL good_count: got %0d exp 3", q.size()); end
    for (int i = 0; i < 3; i++) if (i < q.size()) begin
      checks++; if (q[i] !== exp_q[i]) begin errors++; $display("FAIL good_beat[%0d]: got %h exp %h", i, q[i], exp_q[i]); end
    end
    checks++; if (pkt_cnt !== 5'd0) begin errors++; $display("FAIL good_pkt_end: got %0d exp 0", pkt_cnt); end
  endtask

  task automatic test_overflow();
    out_rdy = 1'b0; q.delete();
    for (int i = 0; i < 20; i++) begin
      in_data = 32'hF000_0000 + i; in_sop = (i == 0); in_eop = (i == 19);
      in_mod = '0; in_err = 1'b0; in_wren = 1'b1;
      if (i == 16) begin
        checks++; if (in_rdy !== 1'b0) begin errors++; $display("FAIL ovf_in_rdy_full: got %b exp 0", in_rdy); end
        checks++; if (a_full !== 1'b1) begin errors++; $display("FAIL ovf_a_full: got %b exp 1", a_full); end
      end
      if (i == 17) begin
        checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL ovf_in_rdy_rb: got %b exp 1", in_rdy); end
        checks++; if (drop_cnt !== 16'd2) begin errors++; $display("FAIL ovf_drop: got %0d exp 2", drop_cnt); end
        checks++; if (a_full !== 1'b0) begin errors++; $display("FAIL ovf_a_full_rb: got %b exp 0", a_full); end
      end
      cyc();
    end
    idle_in();
    checks++; if (septy !== 1'b1) begin errors++; $display("FAIL ovf_septy: got %b exp 1", septy); end
    checks++; if (pkt_cnt !== 5'd0) begin errors++; $display("FAIL ovf_pkt: got %0d exp 0", pkt_cnt); end
    checks++; if (out_dval !== 1'b0) begin errors++; $display("FAIL ovf_dval: got %b exp 0", out_dval); end
    beat(32'h5151_5151, 1'b1, 1'b1, 2'd1, 1'b0);
    out_rdy = 1'b1;
    repeat (5) cyc();
    checks++; if (q.size() != 1) begin errors++; $display("FAIL ovf_after_count: got %0d exp 1", q.size()); end
    if (q.size() > 0) begin
      checks++; if (q[0] !== pk(32'h5151_5151, 1'b1, 1'b1, 2'd1)) begin errors++; $display("FAIL ovf_after_beat: got %h exp %h", q[0], pk(32'h5151_5151, 1'b1, 1'b1, 2'd1)); end
    end
    checks++; if (drop_cnt !== 16'd2) begin errors++; $display("FAIL ovf_drop_end: got %0d exp 2", drop_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  exp_pkt [12];
    logic [35:0] exp_q [4];
    exp_pkt = '{5'd0, 5'd0, 5'd1, 5'd1, 5'd2, 5'd2, 5'd2, 5'd1, 5'd1, 5'd1, 5'd1, 5'd0};
    q.delete();
    for (int c = 0; c < 12; c++) begin
      out_rdy = (c % 2 == 0);
      idle_in();
      case (c)
        0: begin in_data = 32'hB000_00A0; in_sop = 1'b1; in_wren = 1'b1; end
        1: begin in_data = 32'hB000_00A1; in_eop = 1'b1; in_wren = 1'b1; end
        2: begin in_data = 32'hB000_00B0; in_sop = 1'b1; in_wren = 1'b1; end
        3: begin in_data = 32'hB000_00B1; in_eop = 1'b1; in_mod = 2'd1; in_wren = 1'b1; end
        default: ;
      endcase
      checks++; if (pkt_cnt !== exp_pkt[c]) begin errors++; $display("FAIL b2b_pkt[%0d]: got %0d exp %0d", c, pkt_cnt, exp_pkt[c]); end
      cyc();
    end
    idle_in(); out_rdy = 1'b1;
    repeat (4) cyc();
    exp_q[0] = pk(32'hB000_00A0, 1'b1, 1'b0, 2'd0);
    exp_q[1] = pk(32'hB000_00A1, 1'b0, 1'b1, 2'd0);
    exp_q[2] = pk(32'hB000_00B0, 1'b1, 1'b0, 2'd0);
    exp_q[3] = pk(32'hB000_00B1, 1'b0, 1'b1, 2'd1);
    checks++; if (q.size() != 4) begin errors++; $display("FAIL b2b_count: got %0d exp 4", q.size()); end
    for (int i = 0; i < 4; i++) if (i < q.size()) begin
      checks++; if (q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_beat[%0d]: got %h exp %h", i, q[i], exp_q[i]); end
    end
  endtask

  task automatic test_commit_read_collision();
    logic [35:0] exp_q [3];
    out_rdy = 1'b0; q.delete();
    beat(32'hC000_0000, 1'b1, 1'b1, 2'd0, 1'b0);
    checks++; if (pkt_cnt !== 5'd1) begin errors++; $display("FAIL col_pkt_a: got %0d exp 1", pkt_cnt); end
    cyc();
    checks++; if (out_dval !== 1'b1) begin errors++; $display("FAIL col_dval_a: got %b exp 1", out_dval); end
    beat(32'hD000_0000, 1'b1, 1'b0, 2'd0, 1'b0);
    out_rdy = 1'b1;
    beat(32'hD000_0001, 1'b0, 1'b1, 2'd0, 1'b0);
    checks++; if (pkt_cnt !== 5'd1) begin errors++; $display("FAIL col_pkt_same_edge: got %0d exp 1", pkt_cnt); end
    checks++; if (out_dval !== 1'b0) begin errors++; $display("FAIL col_dval_gap: got %b exp 0", out_dval); end
    repeat (5) cyc();
    exp_q[0] = pk(32'hC000_0000, 1'b1, 1'b1, 2'd0);
    exp_q[1] = pk(32'hD000_0000, 1'b1, 1'b0, 2'd0);
    exp_q[2] = pk(32'hD000_0001, 1'b0, 1'b1, 2'd0);
    checks++; if (q.size() != 3) begin errors++; $display("FAIL col_count: got %0d exp 3", q.size()); end
    for (int i = 0; i < 3; i++) if (i < q.size()) begin
      checks++; if (q[i] !== exp_q[i]) begin errors++; $display("FAIL col_beat[%0d]: got %h exp %h", i, q[i], exp_q[i]); end
    end
    checks++; if (pkt_cnt !== 5'd0) begin errors++; $display("FAIL col_pkt_end: got %0d exp 0", pkt_cnt); end
  endtask

  task automatic test_restart();
    logic [35:0] exp_q [3];
    out_rdy = 1'b1; q.delete();
    beat(32'h7000_0000, 1'b1, 1'b0, 2'd0, 1'b0);
    beat(32'h7000_0001, 1'b0, 1'b0, 2'd0, 1'b0);
    beat(32'h8000_0000, 1'b1, 1'b0, 2'd0, 1'b0);
    checks++; if (drop_cnt !== 16'd3) begin errors++; $display("FAIL rst_frame_drop: got %0d exp 3", drop_cnt); end
    beat(32'h8000_0001, 1'b0, 1'b0, 2'd0, 1'b0);
    beat(32'h8000_0002, 1'b0, 1'b1, 2'd2, 1'b0);
    repeat (6) cyc();
    exp_q[0] = pk(32'h8000_0000, 1'b1, 1'b0, 2'd0);
    exp_q[1] = pk(32'h8000_0001, 1'b0, 1'b0, 2'd0);
    exp_q[2] = pk(32'h8000_0002, 1'b0, 1'b1, 2'd2);
    checks++; if (q.size() != 3) begin errors++; $display("FAIL restart_count: got %0d exp 3", q.size()); end
    for (int i = 0; i < 3; i++) if (i < q.size()) begin
      checks++; if (q[i] !== exp_q[i]) begin errors++; $display("FAIL restart_beat[%0d]: got %h exp %h", i, q[i], exp_q[i]); end
    end
    checks++; if (pkt_cnt !== 5'd0) begin errors++; $display("FAIL restart_pkt: got %0d exp 0", pkt_cnt); end
  endtask

  task automatic test_reset_mid_frame();
    logic [35:0] exp_q [2];
    out_rdy = 1'b0; q.delete();
    beat(32'h9000_0000, 1'b1, 1'b0, 2'd0, 1'b0);
    beat(32'h9000_0001, 1'b0, 1'b1, 2'd0, 1'b0);
    cyc();
    checks++; if (pkt_cnt !== 5'd1) begin errors++; $display("FAIL rmf_pkt_pre: got %0d exp 1", pkt_cnt); end
    checks++; if (out_dval !== 1'b1) begin errors++; $display("FAIL rmf_dval_pre: got %b exp 1", out_dval); end
    beat(32'h9100_0000, 1'b1, 1'b0, 2'd0, 1'b0);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    checks++; if (out_dval !== 1'b0) begin errors++; $display("FAIL rmf_dval: got %b exp 0", out_dval); end
    checks++; if (pkt_cnt !== 5'd0) begin errors++; $display("FAIL rmf_pkt: got %0d exp 0", pkt_cnt); end
    checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL rmf_in_rdy: got %b exp 1", in_rdy); end
    checks++; if (septy !== 1'b1) begin errors++; $display("FAIL rmf_septy: got %b exp 1", septy); end
    checks++; if (a_empty !== 1'b1) begin errors++; $display("FAIL rmf_a_empty: got %b exp 1", a_empty); end
    checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL rmf_drop: got %0d exp 0", drop_cnt); end
    out_rdy = 1'b1;
    beat(32'h9200_0000, 1'b1, 1'b0, 2'd0, 1'b0);
    beat(32'h9200_0001, 1'b0, 1'b1, 2'd1, 1'b0);
    repeat (6) cyc();
    exp_q[0] = pk(32'h9200_0000, 1'b1, 1'b0, 2'd0);
    exp_q[1] = pk(32'h9200_0001, 1'b0, 1'b1, 2'd1);
    checks++; if (q.size() != 2) begin errors++; $display("FAIL rmf_count: got %0d exp 2", q.size()); end
    for (int i = 0; i < 2; i++) if (i < q.size()) begin
      checks++; if (q[i] !== exp_q[i]) begin errors++; $display("FAIL rmf_beat[%0d]: got %h exp %h", i, q[i], exp_q[i]); end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete within 100000 ns");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_err_frame();
    test_overflow();
    test_back_to_back();
    test_commit_read_collision();
    test_restart();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
